// File: rtl/brc_pkg.sv
// Shared types and constants for the serial branch comparator.
package brc_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } brc_state_e;

    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/brc_serial_nib_cmp.sv
// Combinational 4-bit unsigned compare used by the nibble-serial scan.
import brc_pkg::*;

module nib_cmp (
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    output logic             eq,
    output logic             lt
);

    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/brc_serial.sv
// Nibble-serial branch comparator, MSB first, with valid/ready on both sides.
// Define BRC_EARLY_EXIT_EN to leave the scan at the first differing nibble.
import brc_pkg::*;

module brc_serial #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic             i_br_un,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_br_equal,
    output logic             o_br_less
);

    localparam int NIBS  = nib_count(WIDTH);
    localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIBS - 1);

    brc_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             equal_q, equal_d;
    logic             less_q, less_d;
    logic             valid_q;
`ifndef BRC_EARLY_EXIT_EN
    logic             decided_q, decided_d;
`endif

    logic [WIDTH-1:0] bias;
    logic [NIB_W-1:0] a_nib, b_nib;
    logic             nib_eq, nib_lt;

    // Flipping the sign bit of both operands maps signed order onto unsigned order.
    assign bias  = {!i_br_un, {(WIDTH-1){1'b0}}};
    assign a_nib = a_q[idx_q*NIB_W +: NIB_W];
    assign b_nib = b_q[idx_q*NIB_W +: NIB_W];

    nib_cmp u_nib_cmp (
        .a  (a_nib),
        .b  (b_nib),
        .eq (nib_eq),
        .lt (nib_lt)
    );

    assign o_ready    = (state_q == IDLE) && !i_reset;
    assign o_valid    = valid_q;
    assign o_br_equal = equal_q;
    assign o_br_less  = less_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        equal_d = equal_q;
        less_d  = less_q;
`ifndef BRC_EARLY_EXIT_EN
        decided_d = decided_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid && o_ready) begin
                    a_d     = i_rs1_data ^ bias;
                    b_d     = i_rs2_data ^ bias;
                    idx_d   = IDX_TOP;
                    equal_d = 1'b0;
                    less_d  = 1'b0;
`ifndef BRC_EARLY_EXIT_EN
                    decided_d = 1'b0;
`endif
                    state_d = SCAN;
                end
            end
            SCAN: begin
`ifdef BRC_EARLY_EXIT_EN
                if (!nib_eq) begin
                    less_d  = nib_lt;
                    equal_d = 1'b0;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    equal_d = 1'b1;
                    less_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
`else
                // Only the most significant differing nibble decides the order.
                if (!decided_q && !nib_eq) begin
                    decided_d = 1'b1;
                    less_d    = nib_lt;
                end
                if (idx_q == '0) begin
                    equal_d = !decided_d;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
`endif
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= IDX_TOP;
            equal_q <= 1'b0;
            less_q  <= 1'b0;
            valid_q <= 1'b0;
`ifndef BRC_EARLY_EXIT_EN
            decided_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            equal_q <= equal_d;
            less_q  <= less_d;
            valid_q <= (state_d == DONE);
`ifndef BRC_EARLY_EXIT_EN
            decided_q <= decided_d;
`endif
        end
    end

endmodule

// File: tb/tb_brc_serial.sv
// Scoreboard bench for brc_serial; expected latency follows BRC_EARLY_EXIT_EN.
module tb_brc_serial;

    localparam int WIDTH = 32;
    localparam int NIBS  = WIDTH / 4;

    logic             i_clk = 1'b0;
    logic             i_reset = 1'b1;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [WIDTH-1:0] i_rs1_data = '0;
    logic [WIDTH-1:0] i_rs2_data = '0;
    logic             i_br_un = 1'b0;
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic             o_br_equal;
    logic             o_br_less;

    brc_serial #(.WIDTH(WIDTH)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .i_br_un    (i_br_un),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_br_equal (o_br_equal),
        .o_br_less  (o_br_less)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic eq;
        logic lt;
        int   lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic un);
        exp_t e;
        int   n;
        e.eq = (a == b);
        e.lt = un ? (a < b) : ($signed(a) < $signed(b));
`ifdef BRC_EARLY_EXIT_EN
        n = 0;
        for (int i = NIBS - 1; i >= 0; i--) begin
            n++;
            if (a[i*4 +: 4] != b[i*4 +: 4]) break;
        end
`else
        n = NIBS;
`endif
        e.lat = n + 1;
        return e;
    endfunction

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic un);
        @(negedge i_clk);
        chk("ready_before_req", o_ready, 1);
        i_valid    = 1'b1;
        i_rs1_data = a;
        i_rs2_data = b;
        i_br_un    = un;
        sb.push_back(model(a, b, un));
        @(posedge i_clk);
        #1;
        i_valid    = 1'b0;
        i_rs1_data = $urandom;
        i_rs2_data = $urandom;
        i_br_un    = ~un;
    endtask

    task automatic collect(input int hold);
        int   cyc = 0;
        logic busy_bad = 1'b0;
        logic eq0, lt0;
        exp_t e;
        do begin
            @(negedge i_clk);
            cyc++;
            if (!o_valid && o_ready) busy_bad = 1'b1;
        end while (!o_valid && cyc < 40);
        chk("ready_low_while_busy", busy_bad, 0);
        e = sb.pop_front();
        if (!o_valid) begin
            chk("valid_timeout", o_valid, 1);
            return;
        end
        chk("latency", cyc, e.lat);
        chk("equal", o_br_equal, e.eq);
        chk("less", o_br_less, e.lt);
        eq0 = o_br_equal;
        lt0 = o_br_less;
        for (int k = 0; k < hold; k++) begin
            i_valid    = 1'b1;
            i_rs1_data = $urandom;
            i_rs2_data = $urandom;
            @(negedge i_clk);
            chk("hold_valid", o_valid, 1);
            chk("hold_equal", o_br_equal, eq0);
            chk("hold_less", o_br_less, lt0);
            chk("hold_ready", o_ready, 0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        @(negedge i_clk);
        chk("valid_drop", o_valid, 0);
        chk("ready_after_done", o_ready, 1);
    endtask

    initial begin
        logic             seen;
        logic [WIDTH-1:0] a, b;

        repeat (2) @(negedge i_clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_equal", o_br_equal, 0);
        chk("rst_less", o_br_less, 0);
        chk("rst_ready", o_ready, 0);
        i_reset = 1'b0;
        #1;
        chk("ready_after_rst", o_ready, 1);

        send(32'h1234_5678, 32'h1234_5678, 1'b1);  collect(0);
        send(32'h1000_0000, 32'h2000_0000, 1'b1);  collect(0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);  collect(0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);  collect(0);
        send(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);  collect(0);
        send(32'h0000_0005, 32'h0000_0003, 1'b1);  collect(5);

        // Abort a scan with reset asserted during cycle 4.
        send(32'h0000_0001, 32'h0000_0000, 1'b1);
        void'(sb.pop_back());
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        @(negedge i_clk);
        chk("ready_in_reset", o_ready, 0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("ready_after_abort", o_ready, 1);
        seen = 1'b0;
        repeat (12) begin
            @(negedge i_clk);
            if (o_valid) seen = 1'b1;
        end
        chk("no_valid_after_abort", seen, 0);
        send(32'h0000_0001, 32'h0000_0000, 1'b1);  collect(0);

        for (int t = 0; t < 8; t++) begin
            a = $urandom;
            b = (t % 3 == 0) ? a : (a ^ (32'h1 << $urandom_range(31, 0)));
            send(a, b, 1'(t % 2));
            collect(t % 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/brc_serial.md
# brc_serial

Multi-cycle branch comparator for the milestone-2 RV32I core. It accepts two 32-bit register operands and a signed/unsigned select over a valid/ready handshake. It scans the operands one 4-bit nibble per cycle, starting at the MSB and moving toward the LSB, and returns registered `equal` and `less` flags over a second valid/ready handshake. It sits between the decode/register-read stage and the branch-resolution logic, and is used where a single-cycle 32-bit compare chain does not meet timing.

## Interface
- `WIDTH`, default 32: operand width; must be a multiple of 4.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  request valid.
- `o_ready`  out  1  block can accept a request.
- `i_rs1_data`  in  WIDTH  operand A.
- `i_rs2_data`  in  WIDTH  operand B.
- `i_br_un`  in  1  1 = unsigned compare, 0 = signed (two's complement).
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  consumer accepts the result.
- `o_br_equal`  out  1  A == B.
- `o_br_less`  out  1  A < B under the selected signedness.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE
  - `o_ready` = 1.
  - On `i_valid && o_ready`: register the operands, with bit WIDTH-1 of both operands inverted when `i_br_un` = 0. This sign bias turns the signed compare into an unsigned one.
  - Set nibble index `idx` = WIDTH/4-1, clear the flags, go to SCAN.
- SCAN: compare nibble `idx` of A against nibble `idx` of B.
  - Nibbles differ: set `less` = (A_nib < B_nib), `equal` = 0, go to DONE.
  - Nibbles equal and `idx` = 0: set `equal` = 1, `less` = 0, go to DONE.
  - Otherwise: `idx` decrements by 1 and the FSM stays in SCAN.
- DONE
  - `o_valid` = 1; the flags hold stable.
  - On `i_ready` = 1: return to IDLE.
  - `i_ready` low holds DONE indefinitely, with the flags and `o_valid` unchanged.
- No new request is accepted until the FSM has returned to IDLE. There is no back-to-back overlap; `o_ready` is 0 in SCAN and DONE.
- Input operands are sampled only at the accepting edge. Changes to `i_rs*` afterward have no effect.
- Reset values: FSM = IDLE, `o_valid` = 0, `o_br_equal` = 0, `o_br_less` = 0, `idx` = WIDTH/4-1.
- `o_ready` = (state == IDLE) && !`i_reset`, so it is 0 during any cycle in which reset is high.
- Reset asserted in SCAN or DONE aborts the operation: no `o_valid` is produced, and the FSM is in IDLE in the cycle after reset is released.

## Timing
- Request accepted at edge 0. SCAN occupies cycles 1..n, where n is the number of nibbles examined. `o_valid` rises in cycle n+1.
- Latency range for WIDTH = 32:
  - First difference in the top nibble: `o_valid` in cycle 2.
  - Equal operands: n = 8, `o_valid` in cycle 9.
- Result handshake completes at the edge where `o_valid && i_ready`. `o_ready` is 1 in the following cycle. Minimum request-to-request spacing is n+2 cycles.
- All outputs are registered except `o_ready`, which is decoded from the FSM state and `i_reset`.

## Configuration
- `BRC_EARLY_EXIT_EN` defined (early exit): SCAN leaves on the first differing nibble, as described above. Latency is data-dependent, 2..WIDTH/4+1 cycles.
- `BRC_EARLY_EXIT_EN` undefined (fixed latency): SCAN always walks all WIDTH/4 nibbles.
  - The first difference is latched into sticky `decided`/`less` registers, and later nibbles are ignored.
  - `equal` = !`decided` at exit.
  - Latency is always WIDTH/4+1 cycles (9 for WIDTH = 32).
- Flag values are identical in both builds.

## Structure
- Shared package `brc_pkg` contains:
  - the FSM state enum `brc_state_e` (IDLE, SCAN, DONE);
  - the constant `NIB_W` = 4;
  - a function returning the nibble count for a given width.
- Sub-module `nib_cmp`: purely combinational 4-bit compare with outputs `eq` and `lt`. It is instantiated once and its select is driven by `idx`.

## Test plan
- Equal operands: A = B = 0x1234_5678, unsigned → `o_valid` in cycle 9, `equal` = 1, `less` = 0.
- Top-nibble difference: A = 0x1000_0000, B = 0x2000_0000, unsigned → `o_valid` in cycle 2 (cycle 9 without `BRC_EARLY_EXIT_EN`), `less` = 1, `equal` = 0.
- Signedness on the same operands, A = 0xFFFF_FFFF, B = 0x0000_0001:
  - signed → `less` = 1;
  - unsigned → `less` = 0.
  - Both cases give `equal` = 0.
- Backpressure: hold `i_ready` = 0 for 5 cycles after `o_valid` rises → flags and `o_valid` stable. `o_ready` = 0 and `i_valid` is ignored throughout.
- Mid-scan reset: A = 0x0000_0001, B = 0x0000_0000, `i_reset` pulsed in cycle 4 → no `o_valid` is produced, `o_ready` = 1 the cycle after reset drops, and a following request completes normally.
